// File: rtl/pkg_processador.sv
// Shared stack-processor constants: data width, stack depth and push-source encodings.
// Imported by the control unit and by the operand stack.
package pkg_processador;

  localparam int WIDTH_DADO         = 16;
  localparam int PROFUNDIDADE_PILHA = 16;

  localparam logic SRC_DADO = 1'b0;
  localparam logic SRC_ULA  = 1'b1;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports, no reset on contents.
// Write lands at the rising edge; reads are combinational.
module pilha_mem #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr_topo,
  input  logic [PTR_W-1:0] raddr_seg,
  output logic [WIDTH-1:0] rdata_topo,
  output logic [WIDTH-1:0] rdata_seg
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata_topo = r_mem[raddr_topo];
  assign rdata_seg  = r_mem[raddr_seg];

endmodule

// File: rtl/pilha_dados.sv
// LIFO operand stack with registered top/next-of-stack views and sticky overflow/underflow flags.
// Every accepted request becomes visible on the outputs one cycle after its clock edge; no backpressure.
module pilha_dados
  import pkg_processador::*;
#(
  parameter  int WIDTH = WIDTH_DADO,
  parameter  int DEPTH = PROFUNDIDADE_PILHA,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             controle_pilha,
  input  logic [WIDTH-1:0] data_pilha,
  input  logic [WIDTH-1:0] resultado_ula,
  output logic [WIDTH-1:0] topo,
  output logic [WIDTH-1:0] segundo,
  output logic [PTR_W:0]   contagem,
  output logic             cheia,
  output logic             vazia,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_UM  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_DOIS = (PTR_W+1)'(2);

  logic [PTR_W:0]   r_cnt;
  logic [WIDTH-1:0] r_topo;
  logic [WIDTH-1:0] r_seg;
  logic             r_cheia;
  logic             r_vazia;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_din;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic [PTR_W:0]   w_cnt_next;
  logic [PTR_W-1:0] w_idx_topo;
  logic [PTR_W-1:0] w_idx_seg;
  logic [WIDTH-1:0] w_rd_topo;
  logic [WIDTH-1:0] w_rd_seg;
  logic [WIDTH-1:0] w_topo_next;
  logic [WIDTH-1:0] w_seg_next;

  assign w_din   = (controle_pilha == SRC_ULA) ? resultado_ula : data_pilha;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_MAX);

  always_comb begin
    w_we       = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    w_cnt_next = r_cnt;
    if (push && pop) begin
      // Replace-top write-back; on an empty stack it degrades to a plain push.
      w_we = 1'b1;
      if (w_empty) begin
        w_cnt_next = r_cnt + CNT_UM;
        w_set_unf  = 1'b1;
      end
    end else if (push) begin
      if (w_full) begin
        w_set_ovf = 1'b1;
      end else begin
        w_we       = 1'b1;
        w_cnt_next = r_cnt + CNT_UM;
      end
    end else if (pop) begin
      if (w_empty) w_set_unf = 1'b1;
      else         w_cnt_next = r_cnt - CNT_UM;
    end
  end

  // Any write targets the new top slot, so only the top view needs the din bypass.
  assign w_idx_topo = w_cnt_next[PTR_W-1:0] - PTR_W'(1);
  assign w_idx_seg  = w_cnt_next[PTR_W-1:0] - PTR_W'(2);

  pilha_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock      (clock),
    .we         (w_we),
    .waddr      (w_idx_topo),
    .wdata      (w_din),
    .raddr_topo (w_idx_topo),
    .raddr_seg  (w_idx_seg),
    .rdata_topo (w_rd_topo),
    .rdata_seg  (w_rd_seg)
  );

  assign w_topo_next = (w_cnt_next == '0) ? '0 : (w_we ? w_din : w_rd_topo);
  assign w_seg_next  = (w_cnt_next < CNT_DOIS) ? '0 : w_rd_seg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_topo  <= '0;
      r_seg   <= '0;
      r_cheia <= 1'b0;
      r_vazia <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_topo  <= w_topo_next;
      r_seg   <= w_seg_next;
      r_cheia <= (w_cnt_next == CNT_MAX);
      r_vazia <= (w_cnt_next == '0);
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  assign topo      = r_topo;
  assign segundo   = r_seg;
  assign contagem  = r_cnt;
  assign cheia     = r_cheia;
  assign vazia     = r_vazia;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_pilha_dados.sv
// Directed bench for pilha_dados: the driver queues the expected state after each edge,
// and a monitor on the falling edge pops and compares it against the stack outputs.
module tb_pilha_dados;

  logic        clock = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic        controle_pilha;
  logic [15:0] data_pilha;
  logic [15:0] resultado_ula;
  logic [15:0] topo;
  logic [15:0] segundo;
  logic [4:0]  contagem;
  logic        cheia;
  logic        vazia;
  logic        overflow;
  logic        underflow;

  typedef struct {
    logic [15:0] topo;
    logic [15:0] seg;
    logic [4:0]  cnt;
    logic        ovf;
    logic        unf;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  always #5 clock = ~clock;

  pilha_dados dut (
    .clock          (clock),
    .reset          (reset),
    .push           (push),
    .pop            (pop),
    .controle_pilha (controle_pilha),
    .data_pilha     (data_pilha),
    .resultado_ula  (resultado_ula),
    .topo           (topo),
    .segundo        (segundo),
    .contagem       (contagem),
    .cheia          (cheia),
    .vazia          (vazia),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  function automatic exp_t mk(input logic [15:0] t, input logic [15:0] s, input int c,
                              input logic o, input logic u);
    exp_t e;
    e.topo = t;
    e.seg  = s;
    e.cnt  = 5'(c);
    e.ovf  = o;
    e.unf  = u;
    e.id   = 0;
    return e;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then hand the expected result to the monitor.
  task automatic step(input logic rst, input logic ps, input logic pp, input logic ctl,
                      input logic [15:0] dp, input logic [15:0] ru, input exp_t e);
    exp_t q;
    reset          = rst;
    push           = ps;
    pop            = pp;
    controle_pilha = ctl;
    data_pilha     = dp;
    resultado_ula  = ru;
    @(posedge clock);
    #1;
    q    = e;
    q.id = step_id;
    step_id++;
    exp_q.push_back(q);
  endtask

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, required %0h", nm, id, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("topo",      e.id, topo,                    e.topo);
        chk("segundo",   e.id, segundo,                 e.seg);
        chk("contagem",  e.id, {11'd0, contagem},       {11'd0, e.cnt});
        chk("cheia",     e.id, {15'd0, cheia},          {15'd0, (e.cnt == 5'd16)});
        chk("vazia",     e.id, {15'd0, vazia},          {15'd0, (e.cnt == 5'd0)});
        chk("overflow",  e.id, {15'd0, overflow},       {15'd0, e.ovf});
        chk("underflow", e.id, {15'd0, underflow},      {15'd0, e.unf});
      end
    end
  end

  function automatic logic [15:0] fill_val(input int idx);
    return (idx == 15) ? 16'h0BEE : 16'h0100 + 16'(idx);
  endfunction

  initial begin : stimulus
    int c;
    reset = 1'b0; push = 1'b0; pop = 1'b0; controle_pilha = 1'b0;
    data_pilha = '0; resultado_ula = '0;

    // Reset and underflow on an empty stack
    step(0, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    step(0, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    step(1, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    step(1, 0, 1, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 1));

    // Push sequence from data_pilha, ALU input carries a decoy
    step(1, 1, 0, 0, 16'h0011, 16'hDEAD, mk(16'h0011, 16'h0000, 1, 0, 1));
    step(1, 1, 0, 0, 16'h0022, 16'hDEAD, mk(16'h0022, 16'h0011, 2, 0, 1));
    step(1, 1, 0, 0, 16'h0033, 16'hDEAD, mk(16'h0033, 16'h0022, 3, 0, 1));
    step(1, 0, 0, 0, 16'h0044, 16'hDEAD, mk(16'h0033, 16'h0022, 3, 0, 1));

    // Replace-top from the ALU, data_pilha carries a decoy
    step(1, 1, 1, 1, 16'h5555, 16'h00AA, mk(16'h00AA, 16'h0022, 3, 0, 1));
    step(1, 0, 1, 0, 16'h0, 16'h0, mk(16'h0022, 16'h0011, 2, 0, 1));

    // Fresh start, fill to full
    step(0, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      step(1, 1, 0, 0, 16'h0100 + 16'(i), 16'hDEAD,
           mk(16'h0100 + 16'(i), (i > 0) ? 16'h0100 + 16'(i - 1) : 16'h0, i + 1, 0, 0));
    step(1, 1, 0, 0, 16'hFFFF, 16'h0, mk(16'h010F, 16'h010E, 16, 1, 0));
    step(1, 1, 1, 0, 16'h0BEE, 16'h0, mk(16'h0BEE, 16'h010E, 16, 1, 0));

    // Drain to empty, then one extra pop
    for (int k = 1; k <= 16; k++) begin
      c = 16 - k;
      step(1, 0, 1, 0, 16'h0, 16'h0,
           mk((c >= 1) ? fill_val(c - 1) : 16'h0, (c >= 2) ? fill_val(c - 2) : 16'h0, c, 1, 0));
    end
    step(1, 0, 1, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 1, 1));

    // Push and pop together on an empty stack acts as a push plus underflow
    step(0, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    step(1, 1, 1, 1, 16'h1111, 16'h0777, mk(16'h0777, 16'h0, 1, 0, 1));

    // Reset in the middle of operation beats a concurrent push
    step(0, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    for (int i = 1; i <= 5; i++)
      step(1, 1, 0, 0, 16'(i), 16'h0, mk(16'(i), (i > 1) ? 16'(i - 1) : 16'h0, i, 0, 0));
    step(1, 0, 0, 0, 16'h0, 16'h0, mk(16'h0005, 16'h0004, 5, 0, 0));
    step(0, 1, 0, 0, 16'h0099, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));
    step(1, 0, 0, 0, 16'h0, 16'h0, mk(16'h0, 16'h0, 0, 0, 0));

    repeat (3) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required stimulus completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pilha_dados.md
Name: pilha_dados

Overview:
- 16-bit LIFO operand stack sitting directly downstream of the control unit (UC) in the stack processor.
- Consumes UC's push, pop, controle_pilha and data_pilha outputs, plus the ALU result.
- Presents top-of-stack and next-of-stack words to the ALU operand path (temp1/temp2 loads).
- Reports occupancy and sticky overflow/underflow errors for debug and verification.

Parameters:
- WIDTH, 16, data word width; matches data_pilha and data_mem.
- DEPTH, 16, number of stack entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- push  in  1  push request from UC.
- pop  in  1  pop request from UC.
- controle_pilha  in  1  push source select: 0 = data_pilha, 1 = resultado_ula.
- data_pilha  in  WIDTH  immediate/memory word from UC.
- resultado_ula  in  WIDTH  ALU result word.
- topo  out  WIDTH  current top-of-stack entry.
- segundo  out  WIDTH  entry directly below the top.
- contagem  out  PTR_W+1  number of valid entries, 0..DEPTH.
- cheia  out  1  contagem == DEPTH.
- vazia  out  1  contagem == 0.
- overflow  out  1  sticky: push rejected because stack full.
- underflow  out  1  sticky: pop rejected because stack empty.

Behaviour:
- Design rules:
  - One clock, named clock.
  - Reset is named reset and is synchronous, active-low. It is sampled only on the rising clock edge while reset == 0.
- Reset:
  - contagem = 0, overflow = 0, underflow = 0, vazia = 1, cheia = 0, topo = 0, segundo = 0.
  - Storage array contents are don't-care after reset.
  - Reset asserted in the same cycle as push or pop takes priority; the request is discarded.
- Push source: din = controle_pilha ? resultado_ula : data_pilha, sampled at the edge.
- Outputs:
  - topo, segundo, contagem, cheia and vazia are registered.
  - Each reflects the operation accepted at edge N from edge N onward, i.e. one-cycle latency from request to visibility.
  - topo reads 0 when contagem == 0; segundo reads 0 when contagem < 2. Never expose stale array data.
- Operation table per rising edge (reset == 1):
  - push=0, pop=0: hold all state.
  - push=1, pop=0, not full: mem[contagem] <= din; contagem+1.
  - push=1, pop=0, full: no write, contagem unchanged, overflow <= 1.
  - push=0, pop=1, not empty: contagem-1; popped value is lost.
  - push=0, pop=1, empty: no change, underflow <= 1.
  - push=1, pop=1, contagem >= 1 (including full): replace-top. mem[contagem-1] <= din; contagem unchanged; no flag. This is the ALU write-back path (pop operand, push result in one cycle).
  - push=1, pop=1, empty: perform push only (contagem becomes 1) and set underflow <= 1.
- Sticky flags clear only on reset.
- Pointer arithmetic:
  - contagem is PTR_W+1 bits wide, so DEPTH is representable.
  - Array index uses the low PTR_W bits.
  - There is no wrap-around; full and empty are hard limits.
- The stack has no internal FSM beyond the occupancy counter. The sequencing (fetch → decode → push/pop) is owned by UC.
- UC guarantees push/pop are single-cycle pulses. Held levels are still legal and act once per edge.

Decomposition:
- Shared package pkg_processador holds WIDTH_DADO = 16, PROFUNDIDADE_PILHA = 16, and the controle_pilha encodings SRC_DADO = 0 and SRC_ULA = 1.
- UC uses the same package.
- One sub-module, pilha_mem: DEPTH×WIDTH register array with one write port (we, waddr, wdata) and two async read ports (raddr_topo, raddr_seg).
- pilha_dados holds the counter, flags, source mux and output registers.

Test Plan:
- Reset/empty: hold reset=0 for 2 cycles, release; pop once → underflow=1, contagem=0, vazia=1, topo=0.
- Push sequence: controle_pilha=0, push data_pilha 0x0011, 0x0022, 0x0033 on successive cycles → topo=0x0033, segundo=0x0022, contagem=3, each visible one cycle after its edge.
- Replace-top: from the previous state, push=pop=1, controle_pilha=1, resultado_ula=0x00AA → topo=0x00AA, segundo=0x0022, contagem=3, no flags set.
- Full/overflow: push 16 words 0x0100..0x010F → cheia=1, topo=0x010F. A 17th push of 0xFFFF → overflow=1, topo remains 0x010F, contagem=16. Then push=pop=1 with 0x0BEE → topo=0x0BEE, contagem=16.
- Drain: pop 16 times → vazia=1, topo=0, segundo=0 once contagem<2. Overflow stays 1 (sticky) until reset.
- Reset mid-operation: contagem=5; assert reset=0 in the same cycle as push=1 → next cycle contagem=0, flags 0, topo=0, push discarded.
